// File: rtl/checkbits_seq_monitor_pkg.sv
// Shared types and constants for the checkbits sequence monitor.
package checkbits_mon_pkg;

  localparam int SYNC_STAGES   = 2;
  localparam int SEQ_DEPTH_DEF = 8;

  // Width of a slot index; a one-slot table still gets a 1-bit index.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(SEQ_DEPTH_DEF);
  localparam int LEN_W_DEF = IDX_W_DEF + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    DONE_PASS = 2'd2,
    DONE_FAIL = 2'd3
  } mon_state_e;

endpackage

// File: rtl/checkbits_seq_monitor_if.sv
// Bus/config/status bundle between the firmware-facing side and the monitor.
interface checkbits_seq_monitor_if
  import checkbits_mon_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SEQ_DEPTH = 8,
  parameter int TIMEOUT_W = 32
);
  localparam int IDX_W = idx_w(SEQ_DEPTH);
  localparam int LEN_W = IDX_W + 1;

  logic [DATA_W-1:0]    bus_in;
  logic                 cfg_we;
  logic [IDX_W-1:0]     cfg_idx;
  logic [DATA_W-1:0]    cfg_data;
  logic [LEN_W-1:0]     cfg_len;
  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic                 start;
  logic                 busy;
  logic                 pass;
  logic                 fail;
  logic [LEN_W-1:0]     match_idx;
  logic [DATA_W-1:0]    stable_val;

  modport master (
    output bus_in, cfg_we, cfg_idx, cfg_data, cfg_len, timeout_cycles, start,
    input  busy, pass, fail, match_idx, stable_val
  );

  modport slave (
    input  bus_in, cfg_we, cfg_idx, cfg_data, cfg_len, timeout_cycles, start,
    output busy, pass, fail, match_idx, stable_val
  );
endinterface

// File: rtl/checkbits_seq_monitor_bus_stable_sync.sv
// Two-flop synchronizer plus stability filter for the checkbits pad word.
// A value is accepted once STABLE_CYCLES consecutive synchronized samples agree
// and it differs from the value currently held.
module bus_stable_sync
  import checkbits_mon_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_bus,
  output logic [DATA_W-1:0] o_stable_val,
  output logic              o_new_val
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [DATA_W-1:0] r_sync [SYNC_STAGES];
  logic [DATA_W-1:0] r_cand;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_stable;
  logic              r_new_val;

  logic [DATA_W-1:0] w_sample;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_hit;

  assign w_sample     = r_sync[SYNC_STAGES-1];
  assign o_stable_val = r_stable;
  assign o_new_val    = r_new_val;

  // Metastability chain per bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_bus;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Run-length of the current candidate (saturating) and acceptance decision.
  always_comb begin
    w_cnt_next = CNT_W'(1);
    if (w_sample == r_cand) begin
      w_cnt_next = (r_cnt == CNT_W'(STABLE_CYCLES)) ? r_cnt : r_cnt + 1'b1;
    end
    w_hit = (w_cnt_next == CNT_W'(STABLE_CYCLES)) && (w_sample != r_stable);
  end

  // Candidate tracking and debounced value/strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cand    <= '0;
      r_cnt     <= '0;
      r_stable  <= '0;
      r_new_val <= 1'b0;
    end else begin
      r_cand    <= w_sample;
      r_cnt     <= w_cnt_next;
      r_new_val <= w_hit;
      if (w_hit) r_stable <= w_sample;
    end
  end
endmodule

// File: rtl/checkbits_seq_monitor.sv
// Checkbits sequence monitor: waits for a programmed ordered list of debounced
// GPIO values and reports pass, or fail on timeout.
//
//   state     | meaning
//   IDLE      | after reset, config writable, waiting for start
//   ARMED     | tracking the sequence, timer running, config locked
//   DONE_PASS | all values seen in order; results held; start re-arms
//   DONE_FAIL | timer expired first; results held; start re-arms
module checkbits_seq_monitor
  import checkbits_mon_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int SEQ_DEPTH     = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_W     = 32
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  checkbits_seq_monitor_if.slave mon
);
  localparam int IDX_W = idx_w(SEQ_DEPTH);
  localparam int LEN_W = IDX_W + 1;

  mon_state_e           r_state;
  mon_state_e           w_state_next;
  logic [DATA_W-1:0]    r_slot [SEQ_DEPTH];
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_match_idx;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic [TIMEOUT_W-1:0] r_timer;
  logic                 r_pass;
  logic                 r_fail;

  logic [DATA_W-1:0]    w_stable_val;
  logic                 w_unused_new_val;
  logic [LEN_W-1:0]     w_len_clamped;
  logic                 w_slot_hit;
  logic                 w_last;
  logic                 w_expire;
  logic                 w_arm;
  logic                 w_adv;
  logic                 w_set_pass;
  logic                 w_set_fail;

  // The comparator works on the held level, so the update strobe has no consumer here.
  bus_stable_sync #(
    .DATA_W        (DATA_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sync (
    .clk          (ap_clk),
    .rst          (ap_rst),
    .i_bus        (mon.bus_in),
    .o_stable_val (w_stable_val),
    .o_new_val    (w_unused_new_val)
  );

  assign w_len_clamped = (mon.cfg_len > LEN_W'(SEQ_DEPTH)) ? LEN_W'(SEQ_DEPTH) : mon.cfg_len;
  assign w_slot_hit    = (w_stable_val == r_slot[r_match_idx[IDX_W-1:0]]);
  assign w_last        = ((r_match_idx + LEN_W'(1)) == r_len);
  assign w_expire      = (r_tmo != '0) && (r_timer == (r_tmo - TIMEOUT_W'(1)));

  assign mon.busy       = (r_state == ARMED);
  assign mon.pass       = r_pass;
  assign mon.fail       = r_fail;
  assign mon.match_idx  = r_match_idx;
  assign mon.stable_val = w_stable_val;

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state; completion beats timeout, and a final match pending on the
  // expiry cycle also beats it.
  always_comb begin
    w_state_next = r_state;
    w_arm        = 1'b0;
    w_adv        = 1'b0;
    w_set_pass   = 1'b0;
    w_set_fail   = 1'b0;
    case (r_state)
      ARMED: begin
        if (r_match_idx == r_len) begin
          w_state_next = DONE_PASS;
          w_set_pass   = 1'b1;
        end else if (w_expire && !(w_slot_hit && w_last)) begin
          w_state_next = DONE_FAIL;
          w_set_fail   = 1'b1;
        end else if (w_slot_hit) begin
          w_adv = 1'b1;
        end
      end
      default: begin
        if (mon.start) begin
          w_state_next = ARMED;
          w_arm        = 1'b1;
        end
      end
    endcase
  end

  // Run context: latched length/timeout, saturating timer, progress and results.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_len       <= '0;
      r_tmo       <= '0;
      r_timer     <= '0;
      r_match_idx <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else if (w_arm) begin
      r_len       <= w_len_clamped;
      r_tmo       <= mon.timeout_cycles;
      r_timer     <= '0;
      r_match_idx <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else if (r_state == ARMED) begin
      if (r_timer != '1) r_timer <= r_timer + TIMEOUT_W'(1);
      if (w_adv)         r_match_idx <= r_match_idx + LEN_W'(1);
      if (w_set_pass)    r_pass <= 1'b1;
      if (w_set_fail)    r_fail <= 1'b1;
    end
  end

  // Expected-value table; locked while a run is in progress.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < SEQ_DEPTH; i++) r_slot[i] <= '0;
    end else if (mon.cfg_we && (r_state != ARMED) && (int'(mon.cfg_idx) < SEQ_DEPTH)) begin
      r_slot[mon.cfg_idx] <= mon.cfg_data;
    end
  end
endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// Testbench for checkbits_seq_monitor with a time-based reference model.
module tb_checkbits_seq_monitor;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  checkbits_seq_monitor_if #(.DATA_W(16), .SEQ_DEPTH(8), .TIMEOUT_W(32)) ifc ();

  checkbits_seq_monitor #(
    .DATA_W(16), .SEQ_DEPTH(8), .STABLE_CYCLES(S), .TIMEOUT_W(32)
  ) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .mon    (ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_armed, m_pass, m_fail;
  int          m_idx, m_len;
  longint      m_tmo, m_el;
  logic [15:0] m_stable;
  logic [15:0] m_slot [8];
  logic [15:0] hist [$];
  logic [15:0] alpha [4] = '{16'hAB40, 16'hAB41, 16'hAB51, 16'h1234};

  function automatic logic [22:0] obs();
    return {ifc.busy, ifc.pass, ifc.fail, ifc.match_idx, ifc.stable_val};
  endfunction

  function automatic logic [22:0] expv();
    return {m_armed, m_pass, m_fail, 4'(m_idx), m_stable};
  endfunction

  task automatic model_reset();
    m_armed = 0; m_pass = 0; m_fail = 0;
    m_idx = 0; m_len = 0; m_tmo = 0; m_el = 0;
    m_stable = '0;
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
    hist.delete();
  endtask

  // One clock edge of the model: the bus value seen at an edge reaches the
  // filter two edges later; S equal filtered samples make it the held value.
  task automatic model_edge();
    logic [15:0] pre, c, v;
    bit eq, hit, fin;
    int k;
    pre = m_stable;
    hist.push_back(ifc.bus_in);
    if (hist.size() > 16) void'(hist.pop_front());
    eq = 1; c = '0;
    for (int i = 0; i < S; i++) begin
      k = hist.size() - 3 - i;
      v = (k >= 0) ? hist[k] : 16'h0000;
      if (i == 0) c = v;
      else if (v != c) eq = 0;
    end
    if (eq) m_stable = c;

    if (m_armed) begin
      hit = (m_idx < m_len) && (pre == m_slot[m_idx]);
      fin = hit && (m_idx + 1 == m_len);
      if (m_idx == m_len) begin
        m_pass = 1; m_armed = 0;
      end else if (m_tmo != 0 && m_el + 1 == m_tmo && !fin) begin
        m_fail = 1; m_armed = 0;
      end else if (hit) begin
        m_idx++;
      end
      m_el++;
    end else begin
      if (ifc.cfg_we) m_slot[ifc.cfg_idx] = ifc.cfg_data;
      if (ifc.start) begin
        m_armed = 1; m_len = int'(ifc.cfg_len); m_tmo = longint'(ifc.timeout_cycles);
        m_idx = 0; m_pass = 0; m_fail = 0; m_el = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic [15:0] data);
    ifc.cfg_we = 1; ifc.cfg_idx = 3'(idx); ifc.cfg_data = data;
    step();
    ifc.cfg_we = 0;
  endtask

  task automatic arm(input int len, input int unsigned tmo);
    ifc.cfg_len = 4'(len); ifc.timeout_cycles = tmo; ifc.start = 1;
    step();
    ifc.start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    ifc.bus_in = '0; ifc.cfg_we = 0; ifc.cfg_idx = '0; ifc.cfg_data = '0;
    ifc.cfg_len = '0; ifc.timeout_cycles = '0; ifc.start = 0;
    #23;
    n_checks++;
    if (obs() !== 23'h0) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", obs(), 23'h0);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_basic_sequence();
    logic [15:0] seq [4] = '{16'h0000, 16'hAB40, 16'hAB41, 16'hAB51};
    int c = 0, t3 = -1, tp = -1;
    cfg_write(0, 16'hAB40); cfg_write(1, 16'hAB41); cfg_write(2, 16'hAB51);
    arm(3, 0);
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 10; j++) begin
        ifc.bus_in = seq[s];
        step(); c++;
        if (t3 < 0 && ifc.match_idx == 4'd3) t3 = c;
        if (tp < 0 && ifc.pass) tp = c;
        n_checks++;
        if (obs() !== expv()) begin
          n_fail++; $display("FAIL basic t=%0d got=%h exp=%h", c, obs(), expv());
        end
      end
    end
    n_checks++;
    if (tp - t3 !== 1) begin
      n_fail++; $display("FAIL basic_pass_latency got=%0d exp=1", tp - t3);
    end
    n_checks++;
    if ({ifc.busy, ifc.pass, ifc.fail, ifc.match_idx} !== 7'b0_1_0_0011) begin
      n_fail++; $display("FAIL basic_final got=%b exp=%b",
                         {ifc.busy, ifc.pass, ifc.fail, ifc.match_idx}, 7'b0_1_0_0011);
    end
  endtask

  task automatic test_wait_semantics();
    logic [15:0] seq [5] = '{16'hAB40, 16'h1234, 16'hAB41, 16'h5555, 16'hAB51};
    int c = 0;
    arm(3, 0);
    for (int s = 0; s < 5; s++) begin
      for (int j = 0; j < 10; j++) begin
        ifc.bus_in = seq[s];
        ifc.start  = (s == 2 && j == 3);
        step(); c++;
        n_checks++;
        if (obs() !== expv()) begin
          n_fail++; $display("FAIL wait t=%0d got=%h exp=%h", c, obs(), expv());
        end
      end
    end
    ifc.start = 0;
    n_checks++;
    if (ifc.pass !== 1'b1 || ifc.fail !== 1'b0) begin
      n_fail++; $display("FAIL wait_final got pass=%b fail=%b exp pass=1 fail=0", ifc.pass, ifc.fail);
    end
  endtask

  task automatic test_timeout();
    int fail_at = -1;
    ifc.bus_in = 16'hAB40;
    for (int j = 0; j < 8; j++) step();
    arm(3, 100);
    for (int c = 1; c <= 150; c++) begin
      step();
      if (fail_at < 0 && ifc.fail) fail_at = c;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL timeout t=%0d got=%h exp=%h", c, obs(), expv());
      end
    end
    n_checks++;
    if (fail_at !== 100 || ifc.match_idx !== 4'd1 || ifc.pass !== 1'b0) begin
      n_fail++; $display("FAIL timeout_final got at=%0d idx=%0d pass=%b exp at=100 idx=1 pass=0",
                         fail_at, ifc.match_idx, ifc.pass);
    end
  endtask

  task automatic test_glitch();
    int c = 0;
    arm(3, 0);
    for (int j = 0; j < 17; j++) begin
      ifc.bus_in = (j >= 2 && j < 5) ? 16'hAB41 : 16'hAB40;
      step(); c++;
      n_checks++;
      if (ifc.stable_val === 16'hAB41 || obs() !== expv()) begin
        n_fail++; $display("FAIL glitch t=%0d got=%h exp=%h", c, obs(), expv());
      end
    end
    n_checks++;
    if (ifc.match_idx !== 4'd1) begin
      n_fail++; $display("FAIL glitch_idx got=%0d exp=1", ifc.match_idx);
    end
    for (int j = 0; j < 20; j++) begin
      ifc.bus_in = (j < 10) ? 16'hAB41 : 16'hAB51;
      step();
    end
    n_checks++;
    if (ifc.pass !== 1'b1) begin
      n_fail++; $display("FAIL glitch_complete got pass=%b exp=1", ifc.pass);
    end
  endtask

  task automatic test_match_vs_timeout();
    for (int off = 0; off < 2; off++) begin
      cfg_write(0, 16'hAB51);
      ifc.bus_in = 16'h0000;
      for (int j = 0; j < 8; j++) step();
      arm(1, 20);
      for (int c = 1; c <= 28; c++) begin
        ifc.bus_in = (c > 13 + off) ? 16'hAB51 : 16'h0000;
        step();
        n_checks++;
        if (obs() !== expv()) begin
          n_fail++; $display("FAIL race off=%0d t=%0d got=%h exp=%h", off, c, obs(), expv());
        end
      end
      n_checks++;
      if ({ifc.pass, ifc.fail} !== ((off == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL race_result off=%0d got=%b exp=%b", off, {ifc.pass, ifc.fail},
                           (off == 0) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_reset_mid_and_len0();
    int guard = 0;
    cfg_write(0, 16'hAB40); cfg_write(1, 16'hAB41); cfg_write(2, 16'hAB51);
    ifc.bus_in = 16'h0000;
    for (int j = 0; j < 8; j++) step();
    arm(3, 0);
    ifc.bus_in = 16'hAB40;
    for (int j = 0; j < 10; j++) step();
    ifc.bus_in = 16'hAB41;
    while (ifc.match_idx != 4'd2 && guard < 20) begin step(); guard++; end
    n_checks++;
    if (ifc.match_idx !== 4'd2) begin
      n_fail++; $display("FAIL midrst_pre got idx=%0d exp=2", ifc.match_idx);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if (obs() !== 23'h0) begin
      n_fail++; $display("FAIL midrst_async got=%h exp=%h", obs(), 23'h0);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();

    ifc.bus_in = 16'h1234;
    for (int j = 0; j < 8; j++) step();
    ifc.cfg_len = 4'd0; ifc.timeout_cycles = 0; ifc.start = 1;
    step();
    ifc.start = 0;
    n_checks++;
    if ({ifc.busy, ifc.pass} !== 2'b10) begin
      n_fail++; $display("FAIL len0_armed got busy,pass=%b exp=10", {ifc.busy, ifc.pass});
    end
    ifc.cfg_we = 1; ifc.cfg_idx = 3'd0; ifc.cfg_data = 16'h1234;
    step();
    ifc.cfg_we = 0;
    n_checks++;
    if ({ifc.busy, ifc.pass, ifc.fail} !== 3'b010) begin
      n_fail++; $display("FAIL len0_pass got=%b exp=010", {ifc.busy, ifc.pass, ifc.fail});
    end

    arm(1, 0);
    ifc.cfg_we = 1; ifc.cfg_idx = 3'd0; ifc.cfg_data = 16'h1234;
    step();
    ifc.cfg_we = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL locked_cfg t=%0d got=%h exp=%h", c, obs(), expv());
      end
    end
    n_checks++;
    if (ifc.match_idx !== 4'd0 || ifc.busy !== 1'b1) begin
      n_fail++; $display("FAIL locked_cfg_idx got idx=%0d busy=%b exp idx=0 busy=1",
                         ifc.match_idx, ifc.busy);
    end
    ifc.bus_in = 16'h0000;
    for (int j = 0; j < 10; j++) step();
    n_checks++;
    if (ifc.pass !== 1'b1 || ifc.match_idx !== 4'd1) begin
      n_fail++; $display("FAIL locked_cfg_done got pass=%b idx=%0d exp pass=1 idx=1",
                         ifc.pass, ifc.match_idx);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 8; run++) begin
      for (int i = 0; i < 8; i++) cfg_write(i, alpha[$urandom_range(0, 3)]);
      arm($urandom_range(0, 8), ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 200));
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 5) == 0) ifc.bus_in = alpha[$urandom_range(0, 3)];
        ifc.cfg_we   = ($urandom_range(0, 9) == 0);
        ifc.cfg_idx  = 3'($urandom_range(0, 7));
        ifc.cfg_data = alpha[$urandom_range(0, 3)];
        ifc.start    = ($urandom_range(0, 39) == 0);
        if (ifc.start) begin
          ifc.cfg_len = 4'($urandom_range(0, 8));
          ifc.timeout_cycles = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 200);
        end
        step();
        n_checks++;
        if (obs() !== expv() || (ifc.pass && ifc.fail)) begin
          n_fail++; $display("FAIL random run=%0d t=%0d got=%h exp=%h", run, c, obs(), expv());
        end
      end
      ifc.cfg_we = 0; ifc.start = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic_sequence();
    test_wait_semantics();
    test_timeout();
    test_glitch();
    test_match_vs_timeout();
    test_reset_mid_and_len0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
